// File: rtl/core_clk_en_sequencer_pkg.sv
// Shared types and constants for the core clock-enable sequencer.
package core_clk_pkg;

   localparam int unsigned NUM_CLK_DOM = 6;
   localparam int unsigned CNT_W       = 8;

   // Domain bit positions
   localparam int unsigned DOM_WSRAM = 5;
   localparam int unsigned DOM_PSRAM = 4;
   localparam int unsigned DOM_MAC   = 3;
   localparam int unsigned DOM_L0    = 2;
   localparam int unsigned DOM_OFIFO = 1;
   localparam int unsigned DOM_SFU   = 0;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } dom_state_e;

   typedef logic [NUM_CLK_DOM-1:0] dom_vec_t;

endpackage : core_clk_pkg

// File: rtl/core_clk_en_sequencer_if.sv
// Controller <-> sequencer <-> gating-control signal bundle.
// Optional macro CORE_CLK_EN_FORCE_ON_EN adds the force_on request.
interface core_clk_en_sequencer_if;
   import core_clk_pkg::*;

   dom_vec_t req;
   dom_vec_t busy;
   dom_vec_t ready;
   logic     weights_sram_clk_en;
   logic     psum_sram_clk_en;
   logic     mac_array_clk_en;
   logic     l0_clk_en;
   logic     ofifo_clk_en;
   logic     sfu_clk_en;
   logic     all_idle;
`ifdef CORE_CLK_EN_FORCE_ON_EN
   logic     force_on;
`endif

   // Controller / unit side
   modport master (
      output req, busy,
`ifdef CORE_CLK_EN_FORCE_ON_EN
      output force_on,
`endif
      input  ready, weights_sram_clk_en, psum_sram_clk_en, mac_array_clk_en,
      input  l0_clk_en, ofifo_clk_en, sfu_clk_en, all_idle
   );

   // Sequencer side
   modport slave (
      input  req, busy,
`ifdef CORE_CLK_EN_FORCE_ON_EN
      input  force_on,
`endif
      output ready, weights_sram_clk_en, psum_sram_clk_en, mac_array_clk_en,
      output l0_clk_en, ofifo_clk_en, sfu_clk_en, all_idle
   );

endinterface : core_clk_en_sequencer_if

// File: rtl/clk_en_domain_fsm.sv
// One clock domain's wake / active / hysteresis sequencer.
// Optional macro CORE_CLK_EN_FORCE_ON_EN adds force_on (pins the FSM in ON).
module clk_en_domain_fsm
   import core_clk_pkg::*;
#(
   parameter int unsigned WAKE_CYC = 2,
   parameter int unsigned HYST_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic eff_req,
`ifdef CORE_CLK_EN_FORCE_ON_EN
   input  logic force_on,
`endif
   output logic clk_en,
   output logic ready,
   output logic off_d_c
);

   localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] HYST_LOAD = (HYST_CYC > 0) ? CNT_W'(HYST_CYC - 1) : '0;

   dom_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_en_q, ready_q;

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_OFF: begin
            if (eff_req) begin
               if (WAKE_CYC > 0) begin
                  state_d = ST_WAKE;
                  cnt_d   = WAKE_LOAD;
               end else begin
                  state_d = ST_ON;
               end
            end
         end
         ST_WAKE: begin
            if (cnt_q == '0) state_d = ST_ON;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_ON: begin
            if (!eff_req) begin
               if (HYST_CYC > 0) begin
                  state_d = ST_HOLD;
                  cnt_d   = HYST_LOAD;
               end else begin
                  state_d = ST_OFF;
               end
            end
         end
         ST_HOLD: begin
            if (eff_req)              state_d = ST_ON;
            else if (cnt_q == '0)     state_d = ST_OFF;
            else                      cnt_d   = cnt_q - CNT_W'(1);
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase
`ifdef CORE_CLK_EN_FORCE_ON_EN
      // Forced domains sit in ON; release falls into the normal ON->HOLD path
      if (force_on) begin
         state_d = ST_ON;
         cnt_d   = '0;
      end
`endif
      off_d_c = (state_d == ST_OFF);
   end

   // State, counter and decoded outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_OFF;
         cnt_q    <= '0;
         clk_en_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk_en_q <= (state_d != ST_OFF);
         ready_q  <= (state_d == ST_ON) || (state_d == ST_HOLD);
      end
   end

   assign clk_en = clk_en_q;
   assign ready  = ready_q;

endmodule : clk_en_domain_fsm

// File: rtl/core_clk_en_sequencer.sv
// Per-domain clock-enable sequencer for the core clock-gating control.
// Optional macro CORE_CLK_EN_FORCE_ON_EN adds bus.force_on to hold all domains ON.
module core_clk_en_sequencer
   import core_clk_pkg::*;
#(
   parameter int unsigned WAKE_CYC = 2,
   parameter int unsigned HYST_CYC = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   core_clk_en_sequencer_if.slave   bus
);

   dom_vec_t eff_req_c;
   dom_vec_t clk_en;
   dom_vec_t ready;
   dom_vec_t off_d_c;
   logic     all_idle_q;

   // Effective requests; l0/ofifo follow the registered mac_array activity
   always_comb begin
      eff_req_c            = bus.req | bus.busy;
      eff_req_c[DOM_L0]    = eff_req_c[DOM_L0]    | clk_en[DOM_MAC];
      eff_req_c[DOM_OFIFO] = eff_req_c[DOM_OFIFO] | clk_en[DOM_MAC];
   end

   // One independent FSM per domain
   for (genvar g = 0; g < NUM_CLK_DOM; g++) begin : g_dom
      clk_en_domain_fsm #(
         .WAKE_CYC (WAKE_CYC),
         .HYST_CYC (HYST_CYC)
      ) u_fsm (
         .clk     (clk),
         .reset   (reset),
         .eff_req (eff_req_c[g]),
`ifdef CORE_CLK_EN_FORCE_ON_EN
         .force_on(bus.force_on),
`endif
         .clk_en  (clk_en[g]),
         .ready   (ready[g]),
         .off_d_c (off_d_c[g])
      );
   end

   // all_idle registered alongside the FSM states it summarises
   always_ff @(posedge clk or posedge reset) begin
      if (reset) all_idle_q <= 1'b1;
      else       all_idle_q <= &off_d_c;
   end

   assign bus.ready               = ready;
   assign bus.weights_sram_clk_en = clk_en[DOM_WSRAM];
   assign bus.psum_sram_clk_en    = clk_en[DOM_PSRAM];
   assign bus.mac_array_clk_en    = clk_en[DOM_MAC];
   assign bus.l0_clk_en           = clk_en[DOM_L0];
   assign bus.ofifo_clk_en        = clk_en[DOM_OFIFO];
   assign bus.sfu_clk_en          = clk_en[DOM_SFU];
   assign bus.all_idle            = all_idle_q;

endmodule : core_clk_en_sequencer

// File: tb/tb_core_clk_en_sequencer.sv
// Bench for core_clk_en_sequencer: directed latency scenarios plus randomized
// request/busy traffic against a timestamp-based reference model.
module tb_core_clk_en_sequencer;

   localparam int WAKE = 2;
   localparam int HYST = 16;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   core_clk_en_sequencer_if bus ();

   core_clk_en_sequencer #(
      .WAKE_CYC (WAKE),
      .HYST_CYC (HYST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a domain is enabled from its request cycle+1, ready from
   // request+1+WAKE, and switches off HYST+2 cycles after the last cycle its
   // effective request was seen high once ready (or WAKE end if it dropped early).
   bit m_en   [6];
   int m_rs   [6];
   int m_last [6];
   int cyc;

   function automatic logic [5:0] dut_en();
      return {bus.weights_sram_clk_en, bus.psum_sram_clk_en, bus.mac_array_clk_en,
              bus.l0_clk_en, bus.ofifo_clk_en, bus.sfu_clk_en};
   endfunction

   function automatic logic [5:0] mdl_en();
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = m_en[i];
      return v;
   endfunction

   function automatic logic [5:0] mdl_rdy();
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = m_en[i] && (cyc >= m_rs[i]);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_en[i] = 1'b0; m_rs[i] = 0; m_last[i] = 0;
      end
      cyc = 0;
   endtask

   // Advance one clock, update the model from the inputs seen at the edge
   task automatic tick();
      logic [5:0] eff;
      @(posedge clk);
      eff = bus.req | bus.busy;
      if (m_en[3]) begin
         eff[2] = 1'b1;
         eff[1] = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
         if (!m_en[i]) begin
            if (eff[i]) begin
               m_en[i]   = 1'b1;
               m_rs[i]   = cyc + 1 + WAKE;
               m_last[i] = cyc + WAKE;
            end
         end else begin
            if (cyc >= m_rs[i] && eff[i]) m_last[i] = cyc;
            if (cyc + 1 >= m_last[i] + HYST + 2) m_en[i] = 1'b0;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req  = '0;
      bus.busy = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req  = '0;
      bus.busy = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (dut_en() !== 6'b0) $display("FAIL reset_en: got %b want 000000", dut_en());
      else n_pass++;
      n_chk++;
      if (bus.ready !== 6'b0) $display("FAIL reset_ready: got %b want 000000", bus.ready);
      else n_pass++;
      n_chk++;
      if (bus.all_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", bus.all_idle);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      tick();
      n_chk++;
      if (dut_en() !== 6'b0 || bus.all_idle !== 1'b1)
         $display("FAIL post_reset_idle: en %b idle %b want 000000 1", dut_en(), bus.all_idle);
      else n_pass++;
   endtask

   task automatic test_wake_and_hyst();
      bus.req = 6'b000001;
      tick();
      n_chk++;
      if (dut_en() !== 6'b000001 || bus.ready !== 6'b0 || bus.all_idle !== 1'b0)
         $display("FAIL wake_t1: en %b rdy %b idle %b want 000001 000000 0",
                  dut_en(), bus.ready, bus.all_idle);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.ready !== 6'b0) $display("FAIL wake_t2: rdy %b want 000000", bus.ready);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.ready !== 6'b000001) $display("FAIL wake_t3: rdy %b want 000001", bus.ready);
      else n_pass++;
      repeat (4) tick();
      bus.req = '0;
      for (int k = 1; k <= HYST + 1; k++) begin
         tick();
         n_chk++;
         if (bus.sfu_clk_en !== (k <= HYST) || bus.ready[0] !== (k <= HYST))
            $display("FAIL hyst_k%0d: en %b rdy %b want %b", k, bus.sfu_clk_en,
                     bus.ready[0], (k <= HYST));
         else n_pass++;
      end
      n_chk++;
      if (bus.all_idle !== 1'b1) $display("FAIL hyst_idle: got %b want 1", bus.all_idle);
      else n_pass++;
   endtask

   task automatic test_rearm();
      bus.req = 6'b000001;
      repeat (3) tick();
      bus.req = '0;
      repeat (5) tick();
      bus.req = 6'b000001;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_chk++;
         if (bus.sfu_clk_en !== 1'b1 || bus.ready[0] !== 1'b1)
            $display("FAIL rearm_k%0d: en %b rdy %b want 1 1", k, bus.sfu_clk_en, bus.ready[0]);
         else n_pass++;
      end
      bus.req = '0;
      for (int k = 0; k < 40 && bus.all_idle !== 1'b1; k++) tick();
      n_chk++;
      if (bus.all_idle !== 1'b1) $display("FAIL rearm_drain: idle %b want 1", bus.all_idle);
      else n_pass++;
   endtask

   task automatic test_dependency();
      bus.req = 6'b001000;
      tick();
      n_chk++;
      if (dut_en() !== 6'b001000) $display("FAIL dep_t1: en %b want 001000", dut_en());
      else n_pass++;
      tick();
      n_chk++;
      if (dut_en() !== 6'b001110) $display("FAIL dep_t2: en %b want 001110", dut_en());
      else n_pass++;
      tick();
      n_chk++;
      if (bus.ready !== 6'b001000) $display("FAIL dep_rdy_mac: rdy %b want 001000", bus.ready);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.ready !== 6'b001110) $display("FAIL dep_rdy_all: rdy %b want 001110", bus.ready);
      else n_pass++;
      repeat (5) tick();
      bus.req = '0;
      repeat (HYST) tick();
      n_chk++;
      if (dut_en() !== 6'b001110) $display("FAIL dep_hold: en %b want 001110", dut_en());
      else n_pass++;
      tick();
      n_chk++;
      if (dut_en() !== 6'b000110) $display("FAIL dep_mac_off: en %b want 000110", dut_en());
      else n_pass++;
      repeat (HYST) tick();
      n_chk++;
      if (dut_en() !== 6'b000110) $display("FAIL dep_l0_hold: en %b want 000110", dut_en());
      else n_pass++;
      tick();
      n_chk++;
      if (dut_en() !== 6'b0 || bus.all_idle !== 1'b1)
         $display("FAIL dep_l0_off: en %b idle %b want 000000 1", dut_en(), bus.all_idle);
      else n_pass++;
   endtask

   task automatic test_busy();
      bus.busy = 6'b010000;
      tick();
      n_chk++;
      if (dut_en() !== 6'b010000) $display("FAIL busy_en: en %b want 010000", dut_en());
      else n_pass++;
      repeat (2) tick();
      n_chk++;
      if (bus.ready !== 6'b010000) $display("FAIL busy_rdy: rdy %b want 010000", bus.ready);
      else n_pass++;
      bus.busy = '0;
      repeat (HYST) tick();
      n_chk++;
      if (bus.psum_sram_clk_en !== 1'b1) $display("FAIL busy_hold: en %b want 1", bus.psum_sram_clk_en);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.psum_sram_clk_en !== 1'b0) $display("FAIL busy_off: en %b want 0", bus.psum_sram_clk_en);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wake();
      bus.req = 6'h3F;
      tick();
      n_chk++;
      if (dut_en() !== 6'h3F || bus.ready !== 6'b0)
         $display("FAIL mid_wake_en: en %b rdy %b want 111111 000000", dut_en(), bus.ready);
      else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if (dut_en() !== 6'b0 || bus.ready !== 6'b0 || bus.all_idle !== 1'b1)
         $display("FAIL async_reset: en %b rdy %b idle %b want 000000 000000 1",
                  dut_en(), bus.ready, bus.all_idle);
      else n_pass++;
      bus.req = '0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      tick();
      n_chk++;
      if (dut_en() !== 6'b0 || bus.all_idle !== 1'b1)
         $display("FAIL after_async_reset: en %b idle %b want 000000 1", dut_en(), bus.all_idle);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < 6; i++) begin
            if ($urandom_range(15, 0) == 0) bus.req[i]  = ~bus.req[i];
            if ($urandom_range(31, 0) == 0) bus.busy[i] = ~bus.busy[i];
         end
         tick();
         n_chk++;
         if (dut_en() !== mdl_en())
            $display("FAIL rand_en cyc %0d: got %b want %b", cyc, dut_en(), mdl_en());
         else n_pass++;
         n_chk++;
         if (bus.ready !== mdl_rdy())
            $display("FAIL rand_rdy cyc %0d: got %b want %b", cyc, bus.ready, mdl_rdy());
         else n_pass++;
         n_chk++;
         if (bus.all_idle !== (mdl_en() == 6'b0))
            $display("FAIL rand_idle cyc %0d: got %b want %b", cyc, bus.all_idle, (mdl_en() == 6'b0));
         else n_pass++;
      end
      bus.req  = '0;
      bus.busy = '0;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b1;
      bus.req  = '0;
      bus.busy = '0;
`ifdef CORE_CLK_EN_FORCE_ON_EN
      bus.force_on = 1'b0;
`endif
      model_reset();
      test_reset();
      test_wake_and_hyst();
      test_rearm();
      test_dependency();
      test_busy();
      test_reset_mid_wake();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_core_clk_en_sequencer
